// File: rtl/gpio_pkg.sv
// Shared encodings for the GPIO port bank: address modes, register indices
// and port select values.
package gpio_pkg;

  // Address bits [4:3]: how bits [2:0] are interpreted
  typedef enum logic [1:0] {
    MODE_REG     = 2'b00,
    MODE_DIR_BIT = 2'b01,
    MODE_OUT_BIT = 2'b10,
    MODE_IN_BIT  = 2'b11
  } mode_e;

  // Byte-register indices in MODE_REG; 5..7 are reserved
  localparam logic [2:0] REG_DIR    = 3'd0;
  localparam logic [2:0] REG_OUT    = 3'd1;
  localparam logic [2:0] REG_IN     = 3'd2;
  localparam logic [2:0] REG_CHG    = 3'd3;
  localparam logic [2:0] REG_CHG_EN = 3'd4;

  // Address bits [6:5]: port select
  localparam logic [1:0] PORT_A = 2'b00;
  localparam logic [1:0] PORT_B = 2'b01;
  localparam logic [1:0] PORT_C = 2'b10;
  localparam logic [1:0] PORT_D = 2'b11;

  localparam int NUM_PORTS = 4;

endpackage

// File: rtl/gpio_port_bank_if.sv
// External-data-bus slice seen by the GPIO bank: strobes, address and data.
interface gpio_port_bank_if;
  logic       port_wr_n;
  logic       port_rd_n;
  logic [6:0] port_addr;
  logic [7:0] port_wr_data;
  logic [7:0] port_rd_data;

  modport master (
    output port_wr_n, port_rd_n, port_addr, port_wr_data,
    input  port_rd_data
  );

  modport slave (
    input  port_wr_n, port_rd_n, port_addr, port_wr_data,
    output port_rd_data
  );
endinterface

// File: rtl/gpio_port.sv
// One 8-bit GPIO port: DIR/OUT/CHG/CHG_EN registers, input synchronizer,
// change detector and the local read multiplexer.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  mode_e      mode_i,
  input  logic [2:0] idx_i,
  input  logic [7:0] wr_data_i,
  input  logic [7:0] pad_i,
  output logic [7:0] dir_o,
  output logic [7:0] out_o,
  output logic [7:0] rd_data_o,
  output logic       irq_o
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] in_val;
  logic [7:0] in_prev_q;
  logic [7:0] dir_q, dir_d;
  logic [7:0] out_q, out_d;
  logic [7:0] chg_en_q, chg_en_d;
  logic [7:0] chg_q, chg_d;
  logic [7:0] chg_clr;
  logic [7:0] chg_set;

  assign in_val = sync_q[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous pads plus the previous-cycle copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      in_prev_q <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      in_prev_q <= in_val;
    end
  end

  // Next-state of the software registers; a new change event beats a W1C clear
  always_comb begin
    dir_d    = dir_q;
    out_d    = out_q;
    chg_en_d = chg_en_q;
    chg_clr  = '0;
    if (wr_en_i) begin
      case (mode_i)
        MODE_REG: begin
          case (idx_i)
            REG_DIR:    dir_d    = wr_data_i;
            REG_OUT:    out_d    = wr_data_i;
            REG_CHG:    chg_clr  = wr_data_i;
            REG_CHG_EN: chg_en_d = wr_data_i;
            default: ;
          endcase
        end
        MODE_DIR_BIT: dir_d[idx_i] = wr_data_i[0];
        MODE_OUT_BIT: out_d[idx_i] = wr_data_i[0];
        default: ;
      endcase
    end
    chg_set = (in_val ^ in_prev_q) & chg_en_q;
    chg_d   = chg_set | (chg_q & ~chg_clr);
  end

  // Register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q    <= '0;
      out_q    <= '0;
      chg_en_q <= '0;
      chg_q    <= '0;
    end else begin
      dir_q    <= dir_d;
      out_q    <= out_d;
      chg_en_q <= chg_en_d;
      chg_q    <= chg_d;
    end
  end

  // Local read mux; bit modes return the selected bit in position 0
  always_comb begin
    rd_data_o = '0;
    case (mode_i)
      MODE_REG: begin
        case (idx_i)
          REG_DIR:    rd_data_o = dir_q;
          REG_OUT:    rd_data_o = out_q;
          REG_IN:     rd_data_o = in_val;
          REG_CHG:    rd_data_o = chg_q;
          REG_CHG_EN: rd_data_o = chg_en_q;
          default:    rd_data_o = '0;
        endcase
      end
      MODE_DIR_BIT: rd_data_o = {7'b0, dir_q[idx_i]};
      MODE_OUT_BIT: rd_data_o = {7'b0, out_q[idx_i]};
      MODE_IN_BIT:  rd_data_o = {7'b0, in_val[idx_i]};
      default:      rd_data_o = '0;
    endcase
  end

  assign dir_o = dir_q;
  assign out_o = out_q;
  assign irq_o = |(chg_q & chg_en_q);

endmodule

// File: rtl/gpio_port_bank.sv
// Four-port GPIO responder for the 0x8000-0x807F external-data window:
// write-strobe edge detect, port decode, registered read data and the
// combined change interrupt.
module gpio_port_bank
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_port_bank_if.slave   bus,
  output logic [31:0]       gpio_o,
  output logic [31:0]       gpio_oe,
  input  logic [31:0]       gpio_i,
  output logic              gpio_irq
);

  logic       wr_n_q;
  logic       wr_stb;
  logic [1:0] port_sel;
  mode_e      mode;
  logic [2:0] idx;
  logic [7:0] port_rd [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_irq;
  logic [7:0] rd_data_q;
  logic       irq_q;

  assign port_sel = bus.port_addr[6:5];
  assign mode     = mode_e'(bus.port_addr[4:3]);
  assign idx      = bus.port_addr[2:0];

  // A write fires only on the cycle wr_n is first seen low; resetting the
  // delayed copy to 0 keeps a strobe held through reset from writing
  assign wr_stb = ~bus.port_wr_n & wr_n_q;

  // Delayed copy of the write strobe for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_n_q <= 1'b0;
    end else begin
      wr_n_q <= bus.port_wr_n;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    gpio_port #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_stb && (port_sel == 2'(p))),
      .mode_i    (mode),
      .idx_i     (idx),
      .wr_data_i (bus.port_wr_data),
      .pad_i     (gpio_i[8*p +: 8]),
      .dir_o     (gpio_oe[8*p +: 8]),
      .out_o     (gpio_o[8*p +: 8]),
      .rd_data_o (port_rd[p]),
      .irq_o     (port_irq[p])
    );
  end

  // Read data reloads every cycle rd_n is low, except while a write is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (!bus.port_rd_n && bus.port_wr_n) begin
      rd_data_q <= port_rd[port_sel];
    end
  end

  // Registered OR of every port's enabled change flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |port_irq;
    end
  end

  assign bus.port_rd_data = rd_data_q;
  assign gpio_irq         = irq_q;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Directed bench for gpio_port_bank: stimulus pushes expected outputs with
// the cycle they are due into a scoreboard; a monitor on the falling edge
// compares each entry when its cycle arrives.
module tb_gpio_port_bank;

  localparam int SEL_RD  = 0;
  localparam int SEL_O   = 1;
  localparam int SEL_OE  = 2;
  localparam int SEL_IRQ = 3;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] gpio_i;
  logic [31:0] gpio_o;
  logic [31:0] gpio_oe;
  logic        gpio_irq;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  gpio_port_bank_if bus ();

  gpio_port_bank #(
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .gpio_o   (gpio_o),
    .gpio_oe  (gpio_oe),
    .gpio_i   (gpio_i),
    .gpio_irq (gpio_irq)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp scoreboard entries
  always @(posedge clk) cyc <= cyc + 1;

  // Push an expectation due 'delay' cycles from now
  task automatic checkOutput(input int sel, input logic [31:0] exp,
                             input string name, input int delay = 0);
    exp_t e;
    e.due  = cyc + delay;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Drive the bus for exactly one clock, returning #1 after the edge
  task automatic applyStimulus(input logic wr_n, input logic rd_n,
                               input logic [6:0] addr, input logic [7:0] data);
    bus.port_wr_n    = wr_n;
    bus.port_rd_n    = rd_n;
    bus.port_addr    = addr;
    bus.port_wr_data = data;
    @(posedge clk);
    #1;
  endtask

  // One write access followed by an idle cycle to re-arm the edge detector
  task automatic writeReg(input logic [6:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, addr, data);
    applyStimulus(1'b1, 1'b1, addr, data);
  endtask

  // One read cycle; read data is expected right after the loading edge
  task automatic readReg(input logic [6:0] addr, input logic [7:0] exp,
                         input string name);
    applyStimulus(1'b1, 1'b0, addr, 8'h00);
    checkOutput(SEL_RD, {24'h0, exp}, name);
  endtask

  // Monitor: compare every scoreboard entry whose cycle has come
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].due <= cyc) begin
          logic [31:0] act;
          case (sb[i].sel)
            SEL_RD:  act = {24'h0, bus.port_rd_data};
            SEL_O:   act = gpio_o;
            SEL_OE:  act = gpio_oe;
            default: act = {31'h0, gpio_irq};
          endcase
          checks++;
          if (act !== sb[i].exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     sb[i].name, act, sb[i].exp, cyc);
          end
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  // Directed stimulus sequence
  initial begin
    bus.port_wr_n    = 1'b1;
    bus.port_rd_n    = 1'b1;
    bus.port_addr    = '0;
    bus.port_wr_data = '0;
    gpio_i           = '0;
    rst_n            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput(SEL_OE,  32'h0, "reset gpio_oe");
    checkOutput(SEL_O,   32'h0, "reset gpio_o");
    checkOutput(SEL_RD,  32'h0, "reset rd_data");
    checkOutput(SEL_IRQ, 32'h0, "reset irq");
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 7'h00, 8'h00);
    applyStimulus(1'b1, 1'b1, 7'h00, 8'h00);

    // Port A byte writes and read-back
    writeReg(7'h00, 8'hF0);
    checkOutput(SEL_OE, 32'h0000_00F0, "A DIR byte");
    writeReg(7'h01, 8'hA5);
    checkOutput(SEL_O, 32'h0000_00A5, "A OUT byte");
    readReg(7'h01, 8'hA5, "A OUT read");

    // Port C bit write with wr_n held low five cycles while addr/data move
    writeReg(7'h41, 8'h48);
    checkOutput(SEL_O, 32'h0048_00A5, "C OUT byte");
    applyStimulus(1'b0, 1'b1, 7'h52, 8'h01);
    checkOutput(SEL_O, 32'h004C_00A5, "C OUT bit2 set");
    applyStimulus(1'b0, 1'b1, 7'h52, 8'h00);
    applyStimulus(1'b0, 1'b1, 7'h41, 8'h00);
    applyStimulus(1'b0, 1'b1, 7'h41, 8'h00);
    applyStimulus(1'b0, 1'b1, 7'h52, 8'h00);
    checkOutput(SEL_O, 32'h004C_00A5, "C single update");
    applyStimulus(1'b1, 1'b1, 7'h00, 8'h00);

    // Port B change detect, interrupt and W1C
    writeReg(7'h24, 8'h01);
    gpio_i = 32'h0000_8100;
    checkOutput(SEL_IRQ, 32'h0, "irq before chg", 3);
    checkOutput(SEL_IRQ, 32'h1, "irq raised", 4);
    readReg(7'h22, 8'h00, "B IN pre-sync");
    readReg(7'h22, 8'h00, "B IN in sync");
    readReg(7'h22, 8'h81, "B IN visible");
    readReg(7'h23, 8'h01, "B CHG set");
    writeReg(7'h23, 8'h01);
    checkOutput(SEL_IRQ, 32'h0, "irq cleared");
    readReg(7'h23, 8'h00, "B CHG cleared");

    // Toggle lands on the same edge as a W1C clear: the set must win
    gpio_i = 32'h0000_8000;
    applyStimulus(1'b1, 1'b1, 7'h23, 8'h01);
    applyStimulus(1'b1, 1'b1, 7'h23, 8'h01);
    applyStimulus(1'b0, 1'b1, 7'h23, 8'h01);
    applyStimulus(1'b1, 1'b1, 7'h23, 8'h01);
    readReg(7'h23, 8'h01, "CHG set wins");
    checkOutput(SEL_IRQ, 32'h1, "irq after set wins");
    writeReg(7'h23, 8'h01);
    checkOutput(SEL_IRQ, 32'h0, "irq cleared again");

    // Read-only and reserved locations
    writeReg(7'h02, 8'hFF);
    readReg(7'h02, 8'h00, "A IN after write");
    writeReg(7'h07, 8'hFF);
    readReg(7'h07, 8'h00, "reserved read");
    checkOutput(SEL_OE, 32'h0000_00F0, "oe after reserved");
    checkOutput(SEL_O,  32'h004C_00A5, "o after reserved");

    // Bit-mode reads and a DIR bit write
    readReg(7'h0F, 8'h01, "A DIR bit7");
    readReg(7'h08, 8'h00, "A DIR bit0");
    readReg(7'h3F, 8'h01, "B IN bit7");
    readReg(7'h38, 8'h00, "B IN bit0");
    readReg(7'h52, 8'h01, "C OUT bit2");
    writeReg(7'h08, 8'h01);
    checkOutput(SEL_OE, 32'h0000_00F1, "A DIR bit0 write");

    // Write and read strobes together: write lands, read data holds
    readReg(7'h01, 8'hA5, "A OUT reread");
    applyStimulus(1'b0, 1'b0, 7'h00, 8'h0F);
    checkOutput(SEL_RD, 32'h0000_00A5, "rd hold during write");
    checkOutput(SEL_OE, 32'h0000_000F, "write with rd_n low");
    applyStimulus(1'b1, 1'b1, 7'h00, 8'h00);

    // Reset asserted mid-access, wr_n still low after release
    bus.port_wr_n    = 1'b0;
    bus.port_addr    = 7'h01;
    bus.port_wr_data = 8'hFF;
    rst_n            = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(SEL_OE,  32'h0, "mid reset gpio_oe");
    checkOutput(SEL_O,   32'h0, "mid reset gpio_o");
    checkOutput(SEL_RD,  32'h0, "mid reset rd_data");
    checkOutput(SEL_IRQ, 32'h0, "mid reset irq");
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 7'h01, 8'hFF);
    applyStimulus(1'b0, 1'b1, 7'h01, 8'hFF);
    checkOutput(SEL_O, 32'h0, "no write after reset");
    applyStimulus(1'b1, 1'b1, 7'h01, 8'hFF);
    writeReg(7'h01, 8'h33);
    checkOutput(SEL_O, 32'h0000_0033, "write after rearm");

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
      errors += sb.size();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
